// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO burst reader.
// The prefetch depth fixes how many words may be buffered or in flight at once.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_e;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W     = CNT_W + 1;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order word buffer with simultaneous push/pop and a registered head.
// The caller guarantees no push when full without a pop, and no pop when empty.
module stream_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({i_push, i_pop})
            2'b10: begin
                if (count_q == '0) begin
                    head_d = i_data;
                end else begin
                    tail_d = i_data;
                end
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                // With one entry the incoming word replaces the departing head directly.
                if (count_q == CNT_W'(1)) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_head  = head_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a commanded burst from a 1-cycle-latency FIFO and streams it at one word per cycle.
// Optional STREAM_LAST_EN macro adds the o_last end-of-burst marker.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fifo_re,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] sent_q, sent_d;
    logic             inflight_q;

    logic [CNT_W-1:0] buf_cnt;
    logic [WIDTH-1:0] buf_head;
    logic             handshake;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] limit;
    logic             credit_ok;

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (inflight_q),
        .i_data  (i_fifo_data),
        .i_pop   (handshake),
        .o_count (buf_cnt),
        .o_head  (buf_head)
    );

    assign o_valid   = (buf_cnt != '0);
    assign o_data    = buf_head;
    assign handshake = o_valid & i_ready;

    // A pop may be issued only if its word is guaranteed a slot when it lands.
    assign occupancy = OCC_W'(buf_cnt) + OCC_W'(inflight_q);
    assign limit     = OCC_W'(BUF_DEPTH) + OCC_W'(handshake);
    assign credit_ok = (occupancy < limit);

    assign o_fifo_re = (state_q == RUN) & (issued_q < len_q) & ~i_fifo_empty & credit_ok;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    len_d    = i_len;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (i_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (o_fifo_re) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (handshake) begin
                    sent_d = sent_q + LEN_W'(1);
                end
                if (sent_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= o_fifo_re;
        end
    end

    assign o_busy = (state_q == RUN);
    assign o_done = (state_q == DONE);

`ifdef STREAM_LAST_EN
    assign o_last = o_valid & (sent_q == len_q - LEN_W'(1));
`else
    assign o_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 1-cycle-latency FIFO.
// Build with STREAM_LAST_EN defined to exercise the end-of-burst marker.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy, done, fifo_re, fifo_empty;
    logic [7:0] fifo_data = 8'd0;
    logic       valid;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       last;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .WIDTH (8),
        .LEN_W (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .o_busy       (busy),
        .o_done       (done),
        .o_fifo_re    (fifo_re),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data),
        .o_last       (last)
    );

    // Behavioural FIFO: registered read data one cycle after the read enable.
    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor on the falling edge: records beats and checks stream rules.
    int re_cnt = 0, under_cnt = 0, over_cnt = 0, stall_viol = 0, done_cnt = 0;
    int nbeats = 0, occ = 0;
    logic [7:0] beat_data [256];
    logic       beat_last [256];
    int         beat_cyc  [256];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
            prev_stall = 1'b0;
        end else begin
            if (fifo_re) re_cnt++;
            if (fifo_re && fifo_empty) under_cnt++;
            if (done) done_cnt++;
            if (prev_stall && (!valid || data !== prev_data)) stall_viol++;
            if (valid && ready && nbeats < 256) begin
                beat_data[nbeats] = data;
                beat_last[nbeats] = last;
                beat_cyc[nbeats]  = cyc;
                nbeats++;
            end
            occ = occ + (fifo_re ? 1 : 0) - ((valid && ready) ? 1 : 0);
            if (occ > 2) over_cnt++;
            prev_stall = valid && !ready;
            prev_data  = data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic start_burst(input int n, output int sc);
        start = 1'b1;
        len   = 8'(n);
        sc    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL reset_re got %b want 0", fifo_re); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", data); end
        total++; if (last !== 1'b0) begin bad++; $display("FAIL reset_last got %b want 0", last); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_rate();
        int base, re0, d0, sc;
        bit ok;
        logic exp_last;
        base = nbeats; re0 = re_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        ready = 1'b1;
        start_burst(8, sc);
        wait_done(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_done_timeout got 0 want 1"); end
        tick();
        tick();
        total++; if (nbeats - base !== 8) begin bad++; $display("FAIL full_beats got %0d want 8", nbeats - base); end
        for (int i = 0; i < 8; i++) begin
`ifdef STREAM_LAST_EN
            exp_last = (i == 7);
`else
            exp_last = 1'b0;
`endif
            total++;
            if (beat_data[base+i] !== 8'h10 + 8'(i)) begin
                bad++; $display("FAIL full_data[%0d] got %h want %h", i, beat_data[base+i], 8'h10 + 8'(i));
            end
            total++;
            if (beat_cyc[base+i] !== sc + 3 + i) begin
                bad++; $display("FAIL full_timing[%0d] got %0d want %0d", i, beat_cyc[base+i], sc + 3 + i);
            end
            total++;
            if (beat_last[base+i] !== exp_last) begin
                bad++; $display("FAIL full_last[%0d] got %b want %b", i, beat_last[base+i], exp_last);
            end
        end
        total++; if (re_cnt - re0 !== 8) begin bad++; $display("FAIL full_re_count got %0d want 8", re_cnt - re0); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL full_done_pulses got %0d want 1", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int base, re0, sv0, sc;
        bit ok;
        logic [3:0] pat;
        pat = 4'b1001;
        base = nbeats; re0 = re_cnt; sv0 = stall_viol;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        ready = 1'b1;
        start_burst(4, sc);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ready = pat[i % 4];
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        ready = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL bp_done_timeout got 0 want 1"); end
        tick();
        total++; if (nbeats - base !== 4) begin bad++; $display("FAIL bp_beats got %0d want 4", nbeats - base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (beat_data[base+i] !== 8'h20 + 8'(i)) begin
                bad++; $display("FAIL bp_data[%0d] got %h want %h", i, beat_data[base+i], 8'h20 + 8'(i));
            end
        end
        total++; if (stall_viol - sv0 !== 0) begin bad++; $display("FAIL bp_stable got %0d want 0", stall_viol - sv0); end
        total++; if (over_cnt !== 0) begin bad++; $display("FAIL bp_credit got %0d want 0", over_cnt); end
        total++; if (re_cnt - re0 !== 4) begin bad++; $display("FAIL bp_re_count got %0d want 4", re_cnt - re0); end
    endtask

    task automatic test_starvation();
        int base, re0, d0, sc;
        bit ok;
        base = nbeats; re0 = re_cnt; d0 = done_cnt;
        ready = 1'b1;
        start_burst(3, sc);
        repeat (10) tick();
        total++; if (re_cnt - re0 !== 0) begin bad++; $display("FAIL starve_re got %0d want 0", re_cnt - re0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL starve_busy got %b want 1", busy); end
        total++; if (nbeats - base !== 0) begin bad++; $display("FAIL starve_beats got %0d want 0", nbeats - base); end
        for (int i = 0; i < 3; i++) begin
            push(8'h30 + 8'(i));
            tick();
        end
        wait_done(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL starve_done_timeout got 0 want 1"); end
        tick();
        tick();
        total++; if (nbeats - base !== 3) begin bad++; $display("FAIL starve_beats_after got %0d want 3", nbeats - base); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (beat_data[base+i] !== 8'h30 + 8'(i)) begin
                bad++; $display("FAIL starve_data[%0d] got %h want %h", i, beat_data[base+i], 8'h30 + 8'(i));
            end
        end
        total++; if (under_cnt !== 0) begin bad++; $display("FAIL starve_underflow got %0d want 0", under_cnt); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL starve_done_pulses got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int base, re0, sc;
        base = nbeats; re0 = re_cnt;
        ready = 1'b1;
        start_burst(0, sc);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got %b want 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got %b want 0", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_clear got %b want 0", done); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL zero_valid got %b want 0", valid); end
        total++; if (re_cnt - re0 !== 0) begin bad++; $display("FAIL zero_re got %0d want 0", re_cnt - re0); end
        total++; if (nbeats - base !== 0) begin bad++; $display("FAIL zero_beats got %0d want 0", nbeats - base); end
    endtask

    task automatic test_last();
        int base, sc;
        bit ok;
        logic exp_last;
        base = nbeats;
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        ready = 1'b1;
        start_burst(5, sc);
        wait_done(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL last_done_timeout got 0 want 1"); end
        tick();
        total++; if (nbeats - base !== 5) begin bad++; $display("FAIL last_beats got %0d want 5", nbeats - base); end
        for (int i = 0; i < 5; i++) begin
`ifdef STREAM_LAST_EN
            exp_last = (i == 4);
`else
            exp_last = 1'b0;
`endif
            total++;
            if (beat_last[base+i] !== exp_last) begin
                bad++; $display("FAIL last_flag[%0d] got %b want %b", i, beat_last[base+i], exp_last);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int base, sc;
        bit ok;
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        ready = 1'b0;
        start_burst(6, sc);
        repeat (6) tick();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rst_mid_prefill got %b want 1", valid); end
        rst_n = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", valid); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got %h want 00", data); end
        total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL rst_mid_re got %b want 0", fifo_re); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got %b want 0", done); end
        rst_n = 1'b1;
        tick();
        wr_ptr = rd_ptr;
        base = nbeats;
        push(8'hA0);
        push(8'hA1);
        ready = 1'b1;
        start_burst(2, sc);
        wait_done(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_fresh_timeout got 0 want 1"); end
        tick();
        total++; if (nbeats - base !== 2) begin bad++; $display("FAIL rst_fresh_beats got %0d want 2", nbeats - base); end
        total++; if (beat_data[base] !== 8'hA0) begin bad++; $display("FAIL rst_fresh_data0 got %h want a0", beat_data[base]); end
        total++; if (beat_data[base+1] !== 8'hA1) begin bad++; $display("FAIL rst_fresh_data1 got %h want a1", beat_data[base+1]); end
        total++; if (beat_cyc[base] !== sc + 3) begin bad++; $display("FAIL rst_fresh_latency got %0d want %0d", beat_cyc[base], sc + 3); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_starvation();
        test_zero_len();
        test_last();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
